shift_mult_seq: RTL and testbench

//   Parametrised sequential shift-add multiplier: one bit of B is retired per clock, LSB first.

---
 rtl/shift_mult_seq_pkg.sv | 14 +
 rtl/shift_mult_dp.sv | 67 ++++++
 rtl/shift_mult_seq.sv | 106 ++++++++++
 tb/tb_shift_mult_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_mult_seq_pkg.sv
// Shared types and defaults for the serial shift-add multiplier.
// SHIFT_MULT_SIGNED_EN selects two's-complement arithmetic in shift_mult_dp.
package shift_mult_seq_pkg;

    localparam int DEF_A_WIDTH = 16;
    localparam int DEF_B_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_mult_dp.sv
// Operand registers, adder and accumulator; one multiplier bit per step.
// SHIFT_MULT_SIGNED_EN: sign-extend and subtract a on the final (MSB) step.
module shift_mult_dp
    import shift_mult_seq_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int B_WIDTH = DEF_B_WIDTH,
    localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               clear,
    input  logic               last,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] acc
);

`ifdef SHIFT_MULT_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_sh;
    logic [P_WIDTH-1:0] acc_q;
    logic [A_WIDTH:0]   hi_ext;
    logic [A_WIDTH:0]   a_ext;
    logic [A_WIDTH:0]   sum;
    logic [P_WIDTH-1:0] acc_nxt;
    logic               sub;

    always_comb begin
        hi_ext = {SIGNED_MODE & acc_q[P_WIDTH-1], acc_q[P_WIDTH-1:B_WIDTH]};
        a_ext  = {SIGNED_MODE & a_q[A_WIDTH-1], a_q};
        sub    = SIGNED_MODE & last;
        sum    = hi_ext;
        if (b_sh[0]) begin
            sum = sub ? (hi_ext - a_ext) : (hi_ext + a_ext);
        end
        // Bit shifted out of sum drops into the low half.
        acc_nxt = {sum, acc_q[B_WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_sh  <= '0;
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (load) begin
            a_q   <= a;
            b_sh  <= b;
            acc_q <= '0;
        end else if (step) begin
            b_sh  <= b_sh >> 1;
            acc_q <= acc_nxt;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/shift_mult_seq.sv
// Sequential shift-add multiplier: FSM, step counter and handshakes.
// Arithmetic mode selected by SHIFT_MULT_SIGNED_EN (see shift_mult_dp).
module shift_mult_seq
    import shift_mult_seq_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int B_WIDTH = DEF_B_WIDTH,
    localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] y,
    output logic               busy
);

    localparam int CW = $clog2(B_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(B_WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [P_WIDTH-1:0] y_q;
    logic [P_WIDTH-1:0] acc;
    logic               accept;
    logic               last;

    assign accept = in_valid & in_ready_q & ~abort;
    assign last   = (state == ST_RUN) && (count == LAST_CNT);

    shift_mult_dp #(
        .A_WIDTH(A_WIDTH),
        .B_WIDTH(B_WIDTH)
    ) u_dp (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .step ((state == ST_RUN) & ~abort),
        .clear(abort),
        .last (last),
        .a    (a),
        .b    (b),
        .acc  (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            y_q         <= '0;
        end else if (abort) begin
            state       <= ST_IDLE;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state      <= ST_RUN;
                        count      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state       <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        y_q         <= acc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // acc is frozen in DONE; y_q keeps the last delivered product afterwards.
    assign y         = (state == ST_DONE) ? acc : y_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_mult_seq.sv
// Self-checking bench for shift_mult_seq (A_WIDTH=16, B_WIDTH=8).
module tb_shift_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] y;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_mult_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_mul(input logic [15:0] x,
                                            input logic [7:0] z);
        longint px;
        longint pz;
`ifdef SHIFT_MULT_SIGNED_EN
        px = longint'($signed(x));
        pz = longint'($signed(z));
`else
        px = longint'(x);
        pz = longint'(z);
`endif
        return 24'(px * pz);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction; holds out_ready low for 'hold' cycles once valid.
    task automatic do_mul(input string tag, input logic [15:0] xa,
                          input logic [7:0] xb, input int hold,
                          output logic [23:0] yo);
        int lat;
        int bcnt;
        int w;
        logic [23:0] exp;
        exp = ref_mul(xa, xb);
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 8'($urandom);
        bcnt = int'(busy);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            if (busy) bcnt++;
            a = 16'($urandom);
            b = 8'($urandom);
        end
        check({tag, "_lat"}, 64'(lat), 64'd8);
        check({tag, "_busy"}, 64'(bcnt), 64'd8);
        check({tag, "_y"}, 64'(y), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_v"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_y"}, 64'(y), 64'(exp));
            check({tag, "_hold_r"}, 64'(in_ready), 64'd0);
        end
        yo = y;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov0"}, 64'(out_valid), 64'd0);
        check({tag, "_ir1"}, 64'(in_ready), 64'd1);
        check({tag, "_ykeep"}, 64'(y), 64'(exp));
    endtask

    logic [23:0] r;
    int vcnt;

    initial begin
        rst_n = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("rst_ir", 64'(in_ready), 64'd1);
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifdef SHIFT_MULT_SIGNED_EN
        do_mul("s1", 16'hFFFD, 8'h05, 0, r);
        check("s1_const", 64'(r), 64'hFFFFF1);
        do_mul("s2", 16'h8000, 8'h80, 1, r);
        check("s2_const", 64'(r), 64'h400000);
`else
        do_mul("t1", 16'hFFFF, 8'hFF, 0, r);
        check("t1_const", 64'(r), 64'hFEFF01);
        do_mul("u6", 16'hFFFD, 8'h05, 0, r);
        check("u6_const", 64'(r), 64'h04FFF1);
`endif
        do_mul("t2", 16'h1234, 8'h00, 0, r);
        check("t2_const", 64'(r), 64'h0);
        do_mul("t3", 16'h00A5, 8'h3C, 5, r);

        // Abort at t0+3 while a new operand is offered.
        in_valid = 1'b1;
        a = 16'h0102;
        b = 8'h33;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        in_valid = 1'b1;
        a = 16'h7777;
        b = 8'h77;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        check("ab_ir", 64'(in_ready), 64'd1);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_ov", 64'(out_valid), 64'd0);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid || busy) vcnt++;
        end
        check("ab_quiet", 64'(vcnt), 64'd0);

        // Async reset between edges mid-RUN.
        in_valid = 1'b1;
        a = 16'hABCD;
        b = 8'hEF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ir", 64'(in_ready), 64'd1);
        check("ar_ov", 64'(out_valid), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_y", 64'(y), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_mul("t5", 16'd3, 8'd5, 0, r);
        check("t5_const", 64'(r), 64'd15);

        for (int k = 0; k < 20; k++) begin
            do_mul("rnd", 16'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
